mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 92 +++++++++
 tb/tb_mem_stage.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage of the five-stage MIPS pipeline: registers the execute bus,
// merges synchronous data-SRAM read data for loads and keeps it alive across write-back stalls.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_allowin,
  output logic        ms_allowin,
  input  logic        es_to_ms_valid,
  input  logic [70:0] es_to_ms_bus,
  output logic        ms_to_ws_valid,
  output logic [69:0] ms_to_ws_bus,
  input  logic [31:0] data_sram_rdata,
  output logic [31:0] ms_to_ds_result,
  output logic [4:0]  MS_dest
);

  localparam int ES_TO_MS_BUS_WD = 71;
  localparam int MS_TO_WS_BUS_WD = 70;

  typedef enum logic {LIVE, HELD} hold_state_t;

  hold_state_t                 state;
  logic                        ms_valid;
  logic                        ms_fresh;
  logic [31:0]                 rdata_hold;
  logic [ES_TO_MS_BUS_WD-1:0]  es_to_ms_bus_r;

  logic        ms_ready_go;
  logic        accept;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [31:0] mem_data;
  logic [31:0] final_result;

  assign {res_from_mem, gr_we, dest, alu_result, pc} = es_to_ms_bus_r;

  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign accept         = es_to_ms_valid && ms_allowin;

  // SRAM read data is only meaningful in the fresh cycle; afterwards use the captured copy
  assign mem_data        = (state == HELD) ? rdata_hold : data_sram_rdata;
  assign final_result    = res_from_mem ? mem_data : alu_result;
  assign ms_to_ds_result = final_result;
  assign MS_dest         = dest & {5{ms_valid && gr_we}};

  assign ms_to_ws_bus = {gr_we, dest, final_result, pc};

  // Acceptance of a new instruction always wins over the hold FSM so a stale
  // captured word can never be reported for the next load.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid       <= 1'b0;
      ms_fresh       <= 1'b0;
      state          <= LIVE;
      rdata_hold     <= 32'h0;
      es_to_ms_bus_r <= '0;
    end else begin
      if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
      end
      if (accept) begin
        es_to_ms_bus_r <= es_to_ms_bus;
      end
      ms_fresh <= accept;

      if (accept) begin
        state <= LIVE;
      end else begin
        case (state)
          LIVE: begin
            if (ms_valid && ms_fresh && res_from_mem && !ws_allowin) begin
              state      <= HELD;
              rdata_hold <= data_sram_rdata;
            end
          end
          HELD: begin
            if (ws_allowin) begin
              state <= LIVE;
            end
          end
          default: state <= LIVE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected write-back results are queued when an
// instruction is offered and compared every cycle the stage presents it.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [70:0] es_to_ms_bus;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [31:0] data_sram_rdata;
  logic [31:0] ms_to_ds_result;
  logic [4:0]  MS_dest;

  typedef struct {
    logic        we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } exp_t;

  exp_t expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ws_allowin      (ws_allowin),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .data_sram_rdata (data_sram_rdata),
    .ms_to_ds_result (ms_to_ds_result),
    .MS_dest         (MS_dest)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
  endtask

  function automatic logic [70:0] mkBus(input logic rfm, input logic we, input logic [4:0] dest,
                                        input logic [31:0] alu, input logic [31:0] pc);
    return {rfm, we, dest, alu, pc};
  endfunction

  task automatic pushExp(input logic we, input logic [4:0] dest, input logic [31:0] result, input logic [31:0] pc);
    exp_t e;
    e.we = we; e.dest = dest; e.result = result; e.pc = pc;
    expQ.push_back(e);
  endtask

  // Drive one cycle of inputs, then step past the next rising edge
  task automatic applyStimulus(input logic rst, input logic ws, input logic esv,
                               input logic [70:0] bus, input logic [31:0] rdata);
    reset           = rst;
    ws_allowin      = ws;
    es_to_ms_valid  = esv;
    es_to_ms_bus    = bus;
    data_sram_rdata = rdata;
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle monitor: whatever is offered must match the scoreboard head
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (ms_to_ws_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious_valid", 32'(ms_to_ws_valid), 32'h0);
        end else begin
          checkOutput("final_result", ms_to_ws_bus[63:32], expQ[0].result);
          checkOutput("bus_dest", 32'(ms_to_ws_bus[68:64]), 32'(expQ[0].dest));
          checkOutput("bus_gr_we", 32'(ms_to_ws_bus[69]), 32'(expQ[0].we));
          checkOutput("bus_pc", ms_to_ws_bus[31:0], expQ[0].pc);
          checkOutput("ds_result", ms_to_ds_result, expQ[0].result);
          checkOutput("MS_dest", 32'(MS_dest), expQ[0].we ? 32'(expQ[0].dest) : 32'h0);
          checkOutput("ms_allowin", 32'(ms_allowin), 32'(ws_allowin));
          if (ws_allowin) void'(expQ.pop_front());
        end
      end else if (ms_to_ws_valid === 1'b0) begin
        checkOutput("idle_MS_dest", 32'(MS_dest), 32'h0);
        checkOutput("idle_allowin", 32'(ms_allowin), 32'h1);
      end else begin
        checkOutput("valid_known", 32'(ms_to_ws_valid), 32'h0);
      end
    end
  end

  initial begin
    // Reset held for two cycles
    applyStimulus(1, 1, 0, '0, 32'h0);
    applyStimulus(1, 1, 0, '0, 32'h0);
    checkOutput("rst_valid", 32'(ms_to_ws_valid), 32'h0);
    checkOutput("rst_MS_dest", 32'(MS_dest), 32'h0);
    checkOutput("rst_allowin", 32'(ms_allowin), 32'h1);
    checkOutput("rst_ds_result", ms_to_ds_result, 32'h0);

    // Back-to-back ALU instructions
    for (int i = 1; i <= 4; i++) begin
      pushExp(1'b1, 5'(i), 32'(i * 17), 32'h1000 + 32'(i * 4));
      applyStimulus(0, 1, 1, mkBus(0, 1, 5'(i), 32'(i * 17), 32'h1000 + 32'(i * 4)), $urandom);
      if (i == 1) checkOutput("first_valid", 32'(ms_to_ws_valid), 32'h1);
    end
    applyStimulus(0, 1, 0, '0, $urandom);
    applyStimulus(0, 1, 0, '0, $urandom);

    // Load without stall
    pushExp(1'b1, 5'd5, 32'hDEADBEEF, 32'h2000);
    applyStimulus(0, 1, 1, mkBus(1, 1, 5'd5, 32'h100, 32'h2000), $urandom);
    applyStimulus(0, 1, 0, '0, 32'hDEADBEEF);
    applyStimulus(0, 1, 0, '0, $urandom);

    // Load with a three-cycle write-back stall
    pushExp(1'b1, 5'd6, 32'hCAFEF00D, 32'h2004);
    applyStimulus(0, 1, 1, mkBus(1, 1, 5'd6, 32'h104, 32'h2004), $urandom);
    applyStimulus(0, 0, 0, '0, 32'hCAFEF00D);
    applyStimulus(0, 0, 0, '0, 32'h0);
    applyStimulus(0, 0, 0, '0, 32'h12345678);
    applyStimulus(0, 1, 0, '0, 32'h77777777);
    applyStimulus(0, 1, 0, '0, $urandom);

    // Stalled non-load without register write: ALU result must pass through
    pushExp(1'b0, 5'd7, 32'h0BADF00D, 32'h2008);
    applyStimulus(0, 1, 1, mkBus(0, 0, 5'd7, 32'h0BADF00D, 32'h2008), $urandom);
    applyStimulus(0, 0, 0, '0, 32'h11111111);
    applyStimulus(0, 0, 0, '0, 32'h22222222);
    applyStimulus(0, 1, 0, '0, 32'h33333333);

    // Held load leaves on the same edge a new load is accepted
    pushExp(1'b1, 5'd8, 32'hAAAA5555, 32'h200C);
    applyStimulus(0, 1, 1, mkBus(1, 1, 5'd8, 32'h108, 32'h200C), $urandom);
    applyStimulus(0, 0, 0, '0, 32'hAAAA5555);
    applyStimulus(0, 0, 0, '0, 32'h0);
    pushExp(1'b1, 5'd9, 32'h5555AAAA, 32'h2010);
    applyStimulus(0, 1, 1, mkBus(1, 1, 5'd9, 32'h10C, 32'h2010), 32'h00000001);
    applyStimulus(0, 0, 0, '0, 32'h5555AAAA);
    applyStimulus(0, 1, 0, '0, 32'h99999999);
    applyStimulus(0, 1, 0, '0, $urandom);

    // Reset while a load is held drops it entirely
    pushExp(1'b1, 5'd10, 32'hBBBB0001, 32'h2014);
    applyStimulus(0, 1, 1, mkBus(1, 1, 5'd10, 32'h110, 32'h2014), $urandom);
    applyStimulus(0, 0, 0, '0, 32'hBBBB0001);
    applyStimulus(0, 0, 0, '0, 32'h0);
    applyStimulus(1, 0, 0, '0, 32'h0);
    expQ.delete();
    checkOutput("held_rst_valid", 32'(ms_to_ws_valid), 32'h0);
    checkOutput("held_rst_ds", ms_to_ds_result, 32'h0);
    pushExp(1'b1, 5'd11, 32'h0D0D0D0D, 32'h2018);
    applyStimulus(0, 1, 1, mkBus(1, 1, 5'd11, 32'h114, 32'h2018), $urandom);
    applyStimulus(0, 1, 0, '0, 32'h0D0D0D0D);
    applyStimulus(0, 1, 0, '0, $urandom);
    applyStimulus(0, 1, 0, '0, $urandom);

    checkOutput("drained", 32'(expQ.size()), 32'h0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
